apb_timer: RTL
==============

APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 SHALL have parameter AW, default 32, meaning APB address width.
REQ-002 SHALL have parameter DW, default 32, meaning APB data width and counter width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port psel  input  1  APB select.
REQ-006 SHALL have port penable  input  1  APB access-phase indicator.
REQ-007 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port paddr  input  AW  byte address; only paddr[4:2] decoded, other bits ignored.
REQ-009 SHALL have port pwdata  input  DW  write data.
REQ-010 SHALL have port prdata  output  DW  read data, registered.
REQ-011 SHALL have port pready  output  1  transfer-complete, registered.
REQ-012 SHALL have port pslverr  output  1  error response, valid only while pready=1.
REQ-013 SHALL have port irq  output  1  level interrupt.

Function
REQ-014 SHALL decode register map: 0x00 CTRL (bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN), 0x04 PRESCALE [15:0], 0x08 LOAD [DW-1:0], 0x0C COUNT [DW-1:0], 0x10 STATUS (bit0 EXPIRED, write-1-to-clear); unused bits read 0.
REQ-015 SHALL insert exactly one wait state: pready asserts in the 2nd cycle of psel=1 & penable=1, stays high 1 cycle, then deasserts.
REQ-016 SHALL hold pready=0 whenever penable=0, including the first psel cycle.
REQ-017 SHALL load prdata on the edge that raises pready and hold it until the next access completes.
REQ-018 SHALL commit a write on the rising edge ending the pready=1 cycle; exactly one commit per transfer.
REQ-019 SHALL, for offsets 0x14-0x1C, assert pslverr=1 with pready, return prdata=0, ignore writes; pslverr=0 otherwise.
REQ-020 SHALL, while EN=1, increment prescaler pcnt each clock; when pcnt==PRESCALE, pcnt<=0 and a tick occurs (tick every PRESCALE+1 clocks).
REQ-021 SHALL, on tick: if COUNT!=0, COUNT<=COUNT-1; if COUNT==0, set EXPIRED and then COUNT<=LOAD if AUTO_RELOAD=1, else EN<=0 with COUNT held at 0.
REQ-022 SHALL give periodic expiry every (LOAD+1)*(PRESCALE+1) clocks in auto-reload mode.
REQ-023 SHALL, while EN=0, hold pcnt at 0 and COUNT unchanged.
REQ-024 SHALL clear pcnt to 0 on any committed write to PRESCALE, COUNT or CTRL.
REQ-025 SHALL give APB write to COUNT priority over a same-cycle tick decrement/reload.
REQ-026 SHALL give expiry set priority over a same-cycle STATUS write-1-to-clear (EXPIRED stays 1).
REQ-027 SHALL give hardware EN clear (one-shot expiry) priority over a same-cycle CTRL write setting EN.
REQ-028 SHALL drive irq = EXPIRED & IRQ_EN combinationally from registered state.
REQ-029 SHALL let a COUNT read return the value held before the edge raising pready.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set CTRL, PRESCALE, LOAD, COUNT, STATUS, pcnt, prdata to 0 and pready, pslverr, irq to 0.
REQ-031 SHALL abort an in-flight APB transfer on rst without committing its write.

Verification
REQ-032 SHALL cover register access: write LOAD=0x1234, read back -> prdata=0x00001234, pready high 1 cycle, 2nd access-phase cycle, pslverr=0.
REQ-033 SHALL cover periodic timing: PRESCALE=3, LOAD=4, CTRL=0x7 -> EXPIRED and irq rise every 20 clocks; W1C STATUS=0x1 drops irq.
REQ-034 SHALL cover one-shot: COUNT=2, PRESCALE=0, CTRL=0x1 -> EXPIRED after 3 ticks, CTRL reads 0x0, COUNT stays 0.
REQ-035 SHALL cover errors: read 0x18 -> pready=1, pslverr=1, prdata=0; write 0x14 changes no register.
REQ-036 SHALL cover collisions: COUNT write on a tick edge -> COUNT equals written value; W1C on expiry edge -> EXPIRED=1.
REQ-037 SHALL cover reset: rst mid-write to LOAD during wait state -> LOAD=0, pready=0 next cycle.

Source files
------------

// File: rtl/apb_timer.sv
// APB programmable down-counter timer with prescaler, auto-reload / one-shot
// modes and a level interrupt. APB slave inserts exactly one wait state.
module apb_timer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr,
    output logic          irq
);

    // Word index of each register (paddr[4:2]); indices 5..7 are error slots.
    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_PRESCALE = 3'd1;
    localparam logic [2:0] IDX_LOAD     = 3'd2;
    localparam logic [2:0] IDX_COUNT    = 3'd3;
    localparam logic [2:0] IDX_STATUS   = 3'd4;

    // Programmer-visible state
    logic          r_en;
    logic          r_auto_reload;
    logic          r_irq_en;
    logic [15:0]   r_prescale;
    logic [DW-1:0] r_load;
    logic [DW-1:0] r_count;
    logic          r_expired;
    logic [15:0]   r_pcnt;

    // APB response registers
    logic          r_pready;
    logic          r_pslverr;
    logic [DW-1:0] r_prdata;

    // Decode and handshake
    logic [2:0]    w_idx;
    logic          w_err;
    logic          w_access;
    logic          w_raise;
    logic          w_commit;
    logic          w_wr_ctrl;
    logic          w_wr_prescale;
    logic          w_wr_load;
    logic          w_wr_count;
    logic          w_wr_status;
    logic [DW-1:0] w_rdata;

    // Timer events
    logic          w_tick;
    logic          w_expire;

    // Address bits outside [4:2] are deliberately ignored.
    logic          w_unused_addr;
    assign w_unused_addr = ^{paddr[AW-1:5], paddr[1:0]};

    assign w_idx    = paddr[4:2];
    assign w_err    = (w_idx > IDX_STATUS);
    assign w_access = psel & penable;
    // First access-phase cycle: the edge ending it raises pready.
    assign w_raise  = w_access & ~r_pready;
    // Second access-phase cycle (pready high): the edge ending it commits.
    assign w_commit = w_access & r_pready & pwrite & ~w_err;

    assign w_wr_ctrl     = w_commit & (w_idx == IDX_CTRL);
    assign w_wr_prescale = w_commit & (w_idx == IDX_PRESCALE);
    assign w_wr_load     = w_commit & (w_idx == IDX_LOAD);
    assign w_wr_count    = w_commit & (w_idx == IDX_COUNT);
    assign w_wr_status   = w_commit & (w_idx == IDX_STATUS);

    assign w_tick   = r_en & (r_pcnt == r_prescale);
    assign w_expire = w_tick & (r_count == '0);

    // Read mux: selects register contents, unused bits read as zero.
    always_comb begin
        // NOTE: default first so every path assigns w_rdata and no latch is inferred.
        w_rdata = '0;
        case (w_idx)
            IDX_CTRL:     w_rdata[2:0]  = {r_irq_en, r_auto_reload, r_en};
            IDX_PRESCALE: w_rdata[15:0] = r_prescale;
            IDX_LOAD:     w_rdata       = r_load;
            IDX_COUNT:    w_rdata       = r_count;
            IDX_STATUS:   w_rdata[0]    = r_expired;
            default:      w_rdata       = '0;
        endcase
    end

    // APB response: one wait state, registered data and error.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_pready  <= w_raise;
            r_pslverr <= w_raise & w_err;
            if (w_raise) begin
                r_prdata <= (pwrite | w_err) ? '0 : w_rdata;
            end
        end
    end

    // Prescaler: free-runs while enabled, restarts on reconfiguration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (!r_en || w_tick || w_wr_ctrl || w_wr_prescale || w_wr_count) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

    // Configuration registers written only by software.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
            r_prescale    <= '0;
            r_load        <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_auto_reload <= pwdata[1];
                r_irq_en      <= pwdata[2];
            end
            if (w_wr_prescale) begin
                r_prescale <= pwdata[15:0];
            end
            if (w_wr_load) begin
                r_load <= pwdata;
            end
        end
    end

    // Counter, enable and expiry: hardware events arbitrated against software writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_count   <= '0;
            r_expired <= 1'b0;
        end else begin
            // A software COUNT write beats a same-cycle decrement or reload.
            if (w_wr_count) begin
                r_count <= pwdata;
            end else if (w_tick) begin
                if (r_count != '0) begin
                    r_count <= r_count - DW'(1);
                end else if (r_auto_reload) begin
                    r_count <= r_load;
                end
            end

            // One-shot expiry stops the timer even if software sets EN on the same edge.
            if (w_expire && !r_auto_reload) begin
                r_en <= 1'b0;
            end else if (w_wr_ctrl) begin
                r_en <= pwdata[0];
            end

            // Expiry wins over a same-cycle write-1-to-clear.
            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (w_wr_status && pwdata[0]) begin
                r_expired <= 1'b0;
            end
        end
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign irq     = r_expired & r_irq_en;

endmodule
